mixed_radix_counter: RTL and testbench
======================================

Name: mixed_radix_counter

Overview:
Cascadable multi-digit counter with a separate modulus per digit, for clock/timer displays (e.g. MM:SS = radices 6,10,6,10). It counts up or down, supports synchronous preset with range clamping, and emits a combinational carry/borrow for chaining to a higher-order block such as an hours counter. It is the generalised successor to our single-digit modulo counters and replaces hand-chained per-digit instances.

Parameters:
NUM_DIGITS, 4, number of digits (1..8); digit 0 is least significant.
DIGIT_W, 4, bits per digit value (2..6).
MODULI, {5'd6,5'd10,5'd6,5'd10}, packed NUM_DIGITS fields of DIGIT_W+1 bits. Field i (bits [i*(DIGIT_W+1) +: DIGIT_W+1]) is the modulus of digit i. Legal range 2..2^DIGIT_W. The default gives digit0=10, digit1=6, digit2=10, digit3=6.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
inc  in  1  count-up enable, one step per cycle
dec  in  1  count-down enable, one step per cycle
load  in  1  synchronous preset strobe
load_val  in  NUM_DIGITS*DIGIT_W  preset value; digit i in [i*DIGIT_W +: DIGIT_W]
q  out  NUM_DIGITS*DIGIT_W  registered count, same packing as load_val
carry_out  out  1  combinational; whole counter wraps max->0 this cycle
borrow_out  out  1  combinational; whole counter wraps 0->max this cycle
at_zero  out  1  combinational; all digits == 0
at_max  out  1  combinational; every digit i == MODULI[i]-1
load_err  out  1  registered; previous load clamped at least one digit

Behaviour:
- Reset: reset (synchronous, active-high) on clk rising edge. It forces q=0 and load_err=0. Reset has highest priority and overrides load, inc and dec in the same cycle. Mid-count reset discards the count; there is no partial state.
- Priority per cycle: reset > load > count > hold.
- Count direction:
  - up = inc & ~dec; down = dec & ~inc.
  - inc & dec together is treated as hold: q unchanged, carry_out=borrow_out=0.
- Up count:
  - Digit 0 steps every up cycle. Digit i steps when up and all digits j<i equal MODULI[j]-1.
  - A stepping digit at MODULI[i]-1 wraps to 0; otherwise it increments by 1.
- Down count:
  - Digit i steps when down and all digits j<i equal 0.
  - A stepping digit at 0 wraps to MODULI[i]-1; otherwise it decrements by 1.
- carry_out = up & ~load & ~reset & at_max. borrow_out = down & ~load & ~reset & at_zero. Both are single-cycle and asserted in the same cycle as the wrapping edge's inputs, so a downstream counter can use carry_out directly as its inc.
- Load:
  - q digit i <= load_val digit i if that digit < MODULI[i], else MODULI[i]-1.
  - load_err <= 1 if any digit was clamped, else 0.
  - load_err holds its value until the next load or reset.
  - No carry or borrow is produced on a load cycle, even if inc or dec is high.
- Latency: q updates on the edge after inputs are sampled. Status outputs are combinational from q and the inputs.
- Arithmetic is per digit, with no binary overflow between fields. A digit never holds a value >= its modulus.
- A digit with modulus 2^DIGIT_W wraps naturally; the wrap compare must still use the full DIGIT_W+1-bit modulus.
- Illegal MODULI (<2 or >2^DIGIT_W) is a configuration error: flag it with a simulation-time check. No runtime behaviour is defined for it.

Test Plan:
- Reset, then inc held for 3600 cycles with default params:
  - q steps 0000 -> 0009 -> 0010 ... 5959 -> 0000.
  - carry_out is high exactly once, in the cycle where q=5959 with inc=1.
- From q=0000, dec=1 for one cycle:
  - borrow_out=1 in that cycle; q=5959 next cycle.
  - Then q=5950 with dec=1 gives q=5949 next cycle.
- load with load_val digits {7,12,3,15} (d3..d0), default params:
  - q={5,9,3,9}, load_err=1.
  - A subsequent load of {1,2,3,4} gives q={1,2,3,4} and load_err=0.
- q=0959, inc=dec=1 for 5 cycles:
  - q stays 0959; carry_out and borrow_out stay 0.
  - Then inc alone for one cycle gives q=1000.
- q=5959, inc=1, with reset=1 and load=1 in the same cycle:
  - q=0000 next, carry_out=0, load_err=0.
  - Repeat with load only: q=load_val and carry_out=0.
- Instance with NUM_DIGITS=2, DIGIT_W=3, MODULI={4'd8,4'd3}:
  - inc sweeps q through 24 states; digit0 cycles 0..2, digit1 cycles 0..7.
  - at_max is high only at {7,2}, and the next increment returns q to {0,0} with carry_out=1.

Source files
------------

// File: rtl/mixed_radix_counter.sv
// rtl/mixed_radix_counter.sv - cascadable up/down counter with a separate modulus per digit
module mixed_radix_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [NUM_DIGITS*(DIGIT_W+1)-1:0] MODULI = {5'd6, 5'd10, 5'd6, 5'd10}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inc,
  input  logic                          dec,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] q,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic                          at_zero,
  output logic                          at_max,
  output logic                          load_err
);

  localparam int MW = DIGIT_W + 1;
  localparam int QW = NUM_DIGITS * DIGIT_W;

  logic                  up;
  logic                  down;
  logic [NUM_DIGITS-1:0] is_max;
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS:0]   low_max;
  logic [NUM_DIGITS:0]   low_zero;
  logic [NUM_DIGITS-1:0] clamp_hit;
  logic [QW-1:0]         q_count;
  logic [QW-1:0]         q_load;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("mixed_radix_counter: NUM_DIGITS must be 1..8");
  end
  if (DIGIT_W < 2 || DIGIT_W > 6) begin : g_bad_digit_w
    $error("mixed_radix_counter: DIGIT_W must be 2..6");
  end

  assign up   = inc & ~dec;
  assign down = dec & ~inc;

  // low_max[i] / low_zero[i]: every digit below i sits at its max / at zero
  always_comb begin
    low_max     = '0;
    low_zero    = '0;
    low_max[0]  = 1'b1;
    low_zero[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      low_max[i+1]  = low_max[i] & is_max[i];
      low_zero[i+1] = low_zero[i] & is_zero[i];
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    // Modulus kept at full MW width so a 2^DIGIT_W modulus still compares correctly
    localparam logic [MW-1:0]      MOD = MODULI[gi*MW +: MW];
    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - MW'(1));

    if (MOD < MW'(2) || MOD > MW'(1 << DIGIT_W)) begin : g_bad_modulus
      $error("mixed_radix_counter: MODULI field out of range 2..2^DIGIT_W");
    end

    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] ld;
    logic [DIGIT_W-1:0] nxt;

    assign cur          = q[gi*DIGIT_W +: DIGIT_W];
    assign ld           = load_val[gi*DIGIT_W +: DIGIT_W];
    assign is_max[gi]   = (cur == TOP);
    assign is_zero[gi]  = (cur == '0);
    assign clamp_hit[gi] = ({1'b0, ld} >= MOD);
    assign q_load[gi*DIGIT_W +: DIGIT_W] = clamp_hit[gi] ? TOP : ld;

    always_comb begin
      nxt = cur;
      if (up && low_max[gi]) begin
        nxt = is_max[gi] ? '0 : cur + DIGIT_W'(1);
      end else if (down && low_zero[gi]) begin
        nxt = is_zero[gi] ? TOP : cur - DIGIT_W'(1);
      end
    end

    assign q_count[gi*DIGIT_W +: DIGIT_W] = nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= q_load;
      load_err <= |clamp_hit;
    end else begin
      q        <= q_count;
    end
  end

  assign at_max     = low_max[NUM_DIGITS];
  assign at_zero    = low_zero[NUM_DIGITS];
  assign carry_out  = up & ~load & ~reset & at_max;
  assign borrow_out = down & ~load & ~reset & at_zero;

endmodule

// File: tb/tb_mixed_radix_counter.sv
// tb/tb_mixed_radix_counter.sv - bench for mixed_radix_counter, default and 2-digit instances
module tb_mixed_radix_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic        reset_a = 1'b0, inc_a = 1'b0, dec_a = 1'b0, load_a = 1'b0;
  logic [15:0] load_val_a = '0;
  logic [15:0] q_a;
  logic        carry_a, borrow_a, at_zero_a, at_max_a, load_err_a;

  logic        reset_b = 1'b0, inc_b = 1'b0, dec_b = 1'b0, load_b = 1'b0;
  logic [5:0]  load_val_b = '0;
  logic [5:0]  q_b;
  logic        carry_b, borrow_b, at_zero_b, at_max_b, load_err_b;

  mixed_radix_counter dut_a (
    .clk(clk), .reset(reset_a), .inc(inc_a), .dec(dec_a), .load(load_a),
    .load_val(load_val_a), .q(q_a), .carry_out(carry_a), .borrow_out(borrow_a),
    .at_zero(at_zero_a), .at_max(at_max_a), .load_err(load_err_a)
  );

  mixed_radix_counter #(.NUM_DIGITS(2), .DIGIT_W(3), .MODULI({4'd8, 4'd3})) dut_b (
    .clk(clk), .reset(reset_b), .inc(inc_b), .dec(dec_b), .load(load_b),
    .load_val(load_val_b), .q(q_b), .carry_out(carry_b), .borrow_out(borrow_b),
    .at_zero(at_zero_b), .at_max(at_max_b), .load_err(load_err_b)
  );

  // Model: the whole counter is one integer in 0..total-1; digits come from division
  int ma[8] = '{10, 6, 10, 6, 0, 0, 0, 0};
  int mb[8] = '{3, 8, 0, 0, 0, 0, 0, 0};
  localparam int TA = 3600;
  localparam int TB = 24;

  int va = 0, vb = 0;
  bit lea = 1'b0, leb = 1'b0;
  int ncarry_a = 0, nmax_b = 0, ncarry_b = 0;
  logic [15:0] carry_q_a = '0;

  function automatic logic [31:0] pack(int v, int nd, int m[8], int w);
    logic [31:0] p = '0;
    for (int i = 0; i < nd; i++) begin
      p = p | (32'(v % m[i]) << (i * w));
      v = v / m[i];
    end
    return p;
  endfunction

  function automatic int clamp_val(logic [31:0] lv, int nd, int m[8], int w);
    int v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      int d;
      d = int'((lv >> (i * w)) & ((32'd1 << w) - 32'd1));
      if (d >= m[i]) d = m[i] - 1;
      v = v * m[i] + d;
    end
    return v;
  endfunction

  function automatic bit clamp_err(logic [31:0] lv, int nd, int m[8], int w);
    bit e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (int'((lv >> (i * w)) & ((32'd1 << w) - 32'd1)) >= m[i]) e = 1'b1;
    end
    return e;
  endfunction

  function automatic int model_next(int v, int tot, bit rst, bit ld, bit up, bit dn,
                                    logic [31:0] lv, int nd, int m[8], int w);
    if (rst) return 0;
    if (ld) return clamp_val(lv, nd, m, w);
    if (up && !dn) return (v + 1) % tot;
    if (dn && !up) return (v + tot - 1) % tot;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    va  <= model_next(va, TA, reset_a, load_a, inc_a, dec_a, 32'(load_val_a), 4, ma, 4);
    lea <= reset_a ? 1'b0 : (load_a ? clamp_err(32'(load_val_a), 4, ma, 4) : lea);
    vb  <= model_next(vb, TB, reset_b, load_b, inc_b, dec_b, 32'(load_val_b), 2, mb, 3);
    leb <= reset_b ? 1'b0 : (load_b ? clamp_err(32'(load_val_b), 2, mb, 3) : leb);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_q", 32'(q_a), pack(va, 4, ma, 4));
      check("a_carry", 32'(carry_a), 32'(inc_a && !dec_a && !load_a && !reset_a && va == TA - 1));
      check("a_borrow", 32'(borrow_a), 32'(dec_a && !inc_a && !load_a && !reset_a && va == 0));
      check("a_at_max", 32'(at_max_a), 32'(va == TA - 1));
      check("a_at_zero", 32'(at_zero_a), 32'(va == 0));
      check("a_load_err", 32'(load_err_a), 32'(lea));
      check("b_q", 32'(q_b), pack(vb, 2, mb, 3));
      check("b_carry", 32'(carry_b), 32'(inc_b && !dec_b && !load_b && !reset_b && vb == TB - 1));
      check("b_borrow", 32'(borrow_b), 32'(dec_b && !inc_b && !load_b && !reset_b && vb == 0));
      check("b_at_max", 32'(at_max_b), 32'(vb == TB - 1));
      check("b_at_zero", 32'(at_zero_b), 32'(vb == 0));
      check("b_load_err", 32'(load_err_b), 32'(leb));
      if (carry_a) begin
        ncarry_a  <= ncarry_a + 1;
        carry_q_a <= q_a;
      end
      if (carry_b) ncarry_b <= ncarry_b + 1;
      if (at_max_b) nmax_b <= nmax_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a_val(logic [15:0] v);
    load_a = 1'b1;
    load_val_a = v;
    tick();
    load_a = 1'b0;
  endtask

  int base0, base1, base2;

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    tick();
    tick();
    reset_a = 1'b0;
    reset_b = 1'b0;
    chk_en  = 1'b1;
    check("reset_q_a", 32'(q_a), 32'h0);
    check("reset_err_a", 32'(load_err_a), 32'h0);
    check("reset_q_b", 32'(q_b), 32'h0);

    // Full sweep 0000..5959..0000
    base0 = ncarry_a;
    inc_a = 1'b1;
    repeat (TA) tick();
    inc_a = 1'b0;
    check("sweep_carry_count", 32'(ncarry_a - base0), 32'd1);
    check("sweep_carry_q", 32'(carry_q_a), 32'h5959);
    check("sweep_end_q", 32'(q_a), 32'h0);

    // Borrow from 0000
    dec_a = 1'b1;
    #1;
    check("borrow_at_zero", 32'(borrow_a), 32'd1);
    tick();
    dec_a = 1'b0;
    check("borrow_wrap_q", 32'(q_a), 32'h5959);
    load_a_val(16'h5950);
    dec_a = 1'b1;
    tick();
    dec_a = 1'b0;
    check("dec_5950", 32'(q_a), 32'h5949);

    // Clamped load then clean load
    load_a_val(16'h7C3F);
    check("clamp_q", 32'(q_a), 32'h5939);
    check("clamp_err", 32'(load_err_a), 32'd1);
    load_a_val(16'h1234);
    check("clean_q", 32'(q_a), 32'h1234);
    check("clean_err", 32'(load_err_a), 32'd0);

    // inc and dec together hold
    load_a_val(16'h0959);
    inc_a = 1'b1;
    dec_a = 1'b1;
    repeat (5) begin
      check("hold_carry", 32'(carry_a), 32'd0);
      check("hold_borrow", 32'(borrow_a), 32'd0);
      tick();
    end
    check("hold_q", 32'(q_a), 32'h0959);
    dec_a = 1'b0;
    tick();
    inc_a = 1'b0;
    check("inc_0959", 32'(q_a), 32'h1000);

    // Reset and load beat a pending carry at 5959
    load_a_val(16'h59FF);
    check("clamp2_err", 32'(load_err_a), 32'd1);
    inc_a = 1'b1;
    reset_a = 1'b1;
    load_a = 1'b1;
    load_val_a = 16'h1234;
    #1;
    check("rst_carry", 32'(carry_a), 32'd0);
    tick();
    reset_a = 1'b0;
    load_a = 1'b0;
    inc_a = 1'b0;
    check("rst_q", 32'(q_a), 32'h0);
    check("rst_err", 32'(load_err_a), 32'd0);
    load_a_val(16'h5959);
    inc_a = 1'b1;
    load_a = 1'b1;
    load_val_a = 16'h4321;
    #1;
    check("load_carry", 32'(carry_a), 32'd0);
    tick();
    load_a = 1'b0;
    inc_a = 1'b0;
    check("load_over_inc_q", 32'(q_a), 32'h4321);

    // 2-digit instance: 24-state sweep
    base1 = nmax_b;
    base2 = ncarry_b;
    inc_b = 1'b1;
    repeat (TB - 1) tick();
    check("b_top_q", 32'(q_b), 32'o72);
    check("b_top_at_max", 32'(at_max_b), 32'd1);
    check("b_top_carry", 32'(carry_b), 32'd1);
    tick();
    inc_b = 1'b0;
    check("b_wrap_q", 32'(q_b), 32'h0);
    check("b_max_count", 32'(nmax_b - base1), 32'd1);
    check("b_carry_count", 32'(ncarry_b - base2), 32'd1);

    // Random traffic on both instances
    repeat (3000) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset_a = (r < 2);
      load_a = (r >= 2 && r < 8);
      inc_a = ($urandom_range(0, 3) != 0);
      dec_a = ($urandom_range(0, 3) == 0);
      load_val_a = 16'($urandom);
      r = int'($urandom_range(0, 99));
      reset_b = (r < 2);
      load_b = (r >= 2 && r < 10);
      inc_b = ($urandom_range(0, 2) == 0);
      dec_b = ($urandom_range(0, 2) == 0);
      load_val_b = 6'($urandom);
      tick();
    end
    {reset_a, load_a, inc_a, dec_a} = '0;
    {reset_b, load_b, inc_b, dec_b} = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
